// File: rtl/sweep_freq_detector.sv
// Zero-crossing step estimator for the RX side of the 16-step frequency sweep.
// Counts hysteresis-qualified rising crossings per window and maps the count to a step index.
module sweep_freq_detector #(
  parameter int          WIN_LEN    = 65536,
  parameter int          STEP_CROSS = 8,
  parameter logic [15:0] HYST       = 16'd256,
  parameter int          LOCK_WINS  = 4
) (
  input  logic        GCLK,
  input  logic        reset,
  input  logic        MODULE_ENA,
  input  logic        DIN_VALID,
  input  logic [15:0] DIN,
  output logic [15:0] CROSS_CNT,
  output logic [3:0]  STEP_IDX,
  output logic        STEP_VALID,
  output logic        NO_SIGNAL,
  output logic        LOCKED,
  output logic        STEP_CHANGE
);

  localparam int SCW = $clog2(WIN_LEN);
  localparam int MW  = $clog2(LOCK_WINS + 1);
  localparam logic [SCW-1:0]     LAST_SAMP = SCW'(WIN_LEN - 1);
  localparam logic [16:0]        SC        = 17'(STEP_CROSS);
  localparam logic [16:0]        SC_HALF   = 17'(STEP_CROSS / 2);
  localparam logic [MW-1:0]      LOCK_N    = MW'(LOCK_WINS);
  localparam logic signed [16:0] HYST_P    = $signed({1'b0, HYST});
  localparam logic signed [16:0] HYST_N    = -HYST_P;

  typedef enum logic [1:0] {D_IDLE, D_SUB, D_DONE} div_state_t;

  div_state_t      r_state;
  logic            r_pos;
  logic [SCW-1:0]  r_samp_cnt;
  logic [15:0]     r_x_cnt;
  logic [15:0]     r_cross_cnt;
  logic            r_win_done;
  logic [16:0]     r_rem;
  logic [4:0]      r_q;
  logic [3:0]      r_idx;
  logic            r_no_signal;
  logic            r_locked;
  logic            r_step_valid;
  logic            r_step_change;
  logic            r_prev_ok;
  logic [MW-1:0]   r_match;

  logic signed [16:0] w_din_x;
  logic               w_above;
  logic               w_below;
  logic               w_rise;
  logic               w_last;
  logic [15:0]        w_x_next;
  logic               w_div_go;
  logic [3:0]         w_new_idx;
  logic               w_same;
  logic [MW-1:0]      w_match_next;

  assign w_din_x  = $signed({DIN[15], DIN});
  assign w_above  = w_din_x > HYST_P;
  assign w_below  = w_din_x < HYST_N;
  assign w_rise   = DIN_VALID && !r_pos && w_above;
  assign w_last   = DIN_VALID && (r_samp_cnt == LAST_SAMP);
  assign w_x_next = (r_x_cnt == 16'hFFFF) ? r_x_cnt : r_x_cnt + 16'(w_rise);

  // Quotient is capped at 17 so the divide length is bounded regardless of count.
  assign w_div_go     = (r_rem >= SC) && (r_q < 5'd17);
  assign w_new_idx    = (r_q >= 5'd16) ? 4'd15 : 4'(r_q - 5'd1);
  assign w_same       = r_prev_ok && (w_new_idx == r_idx);
  assign w_match_next = !w_same ? MW'(1) :
                        (r_match >= LOCK_N) ? LOCK_N : r_match + 1'b1;

  always_ff @(posedge GCLK) begin
    if (reset || !MODULE_ENA) begin
      r_state       <= D_IDLE;
      r_pos         <= 1'b0;
      r_samp_cnt    <= '0;
      r_x_cnt       <= '0;
      r_cross_cnt   <= '0;
      r_win_done    <= 1'b0;
      r_rem         <= '0;
      r_q           <= '0;
      r_idx         <= '0;
      r_no_signal   <= 1'b0;
      r_locked      <= 1'b0;
      r_step_valid  <= 1'b0;
      r_step_change <= 1'b0;
      r_prev_ok     <= 1'b0;
      r_match       <= '0;
    end else begin
      r_win_done    <= 1'b0;
      r_step_valid  <= 1'b0;
      r_step_change <= 1'b0;

      if (DIN_VALID) begin
        if (w_above)
          r_pos <= 1'b1;
        else if (w_below)
          r_pos <= 1'b0;
        if (w_last) begin
          r_cross_cnt <= w_x_next;
          r_samp_cnt  <= '0;
          r_x_cnt     <= '0;
          r_win_done  <= 1'b1;
        end else begin
          r_samp_cnt <= r_samp_cnt + 1'b1;
          r_x_cnt    <= w_x_next;
        end
      end

      case (r_state)
        D_IDLE: begin
          if (r_win_done) begin
            r_rem   <= {1'b0, r_cross_cnt} + SC_HALF;
            r_q     <= '0;
            r_state <= D_SUB;
          end
        end
        D_SUB: begin
          if (w_div_go) begin
            r_rem <= r_rem - SC;
            r_q   <= r_q + 1'b1;
          end else begin
            // Results are registered on entry to D_DONE so they are visible during it.
            r_step_valid <= 1'b1;
            r_state      <= D_DONE;
            if (r_q == 5'd0) begin
              r_no_signal <= 1'b1;
              r_match     <= '0;
              r_locked    <= 1'b0;
              r_prev_ok   <= 1'b0;
            end else begin
              r_no_signal   <= 1'b0;
              r_idx         <= w_new_idx;
              r_prev_ok     <= 1'b1;
              r_match       <= w_match_next;
              r_locked      <= (w_match_next >= LOCK_N);
              r_step_change <= r_locked && (w_new_idx != r_idx);
            end
          end
        end
        D_DONE: r_state <= D_IDLE;
        default: r_state <= D_IDLE;
      endcase
    end
  end

  assign CROSS_CNT   = r_cross_cnt;
  assign STEP_IDX    = r_idx;
  assign STEP_VALID  = r_step_valid;
  assign NO_SIGNAL   = r_no_signal;
  assign LOCKED      = r_locked;
  assign STEP_CHANGE = r_step_change;

endmodule

// File: tb/tb_sweep_freq_detector.sv
// Directed bench for sweep_freq_detector with a short window; expected results are hand-computed per window.
module tb_sweep_freq_detector;

  localparam int WIN = 512;
  localparam real TWO_PI = 6.283185307179586;

  typedef struct packed {
    logic [15:0] cnt;
    logic [3:0]  idx;
    logic        ns;
    logic        lk;
    logic        chg;
    logic [7:0]  lat;
  } res_t;

  logic               GCLK = 1'b0;
  logic               reset = 1'b1;
  logic               MODULE_ENA = 1'b1;
  logic               DIN_VALID = 1'b0;
  logic signed [15:0] DIN = '0;
  logic [15:0]        CROSS_CNT;
  logic [3:0]         STEP_IDX;
  logic               STEP_VALID;
  logic               NO_SIGNAL;
  logic               LOCKED;
  logic               STEP_CHANGE;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   end_cyc = 0;
  int   sv_cnt = 0;
  int   rd_ptr = 0;
  int   orphan = 0;
  res_t res_q [64];

  sweep_freq_detector #(
    .WIN_LEN(WIN), .STEP_CROSS(8), .HYST(16'd256), .LOCK_WINS(4)
  ) dut (
    .GCLK(GCLK), .reset(reset), .MODULE_ENA(MODULE_ENA),
    .DIN_VALID(DIN_VALID), .DIN(DIN),
    .CROSS_CNT(CROSS_CNT), .STEP_IDX(STEP_IDX), .STEP_VALID(STEP_VALID),
    .NO_SIGNAL(NO_SIGNAL), .LOCKED(LOCKED), .STEP_CHANGE(STEP_CHANGE)
  );

  always #5 GCLK = ~GCLK;

  always @(posedge GCLK) cyc <= cyc + 1;

  // Capture every result pulse together with its latency from the window's last sample.
  always @(negedge GCLK) begin
    if (STEP_CHANGE && !STEP_VALID) orphan++;
    if (STEP_VALID) begin
      if (sv_cnt < 64)
        res_q[sv_cnt] = '{CROSS_CNT, STEP_IDX, NO_SIGNAL, LOCKED, STEP_CHANGE, 8'(cyc - end_cyc)};
      sv_cnt++;
    end
  end

  function automatic string fmt(res_t r);
    return $sformatf("cnt=%0d idx=%0d ns=%0b lk=%0b chg=%0b lat=%0d",
                     r.cnt, r.idx, r.ns, r.lk, r.chg, r.lat);
  endfunction

  // mode 0: n +/-1000 pulses then negative; 1: sine with n periods; 2: +/-200 noise; 3: zero
  function automatic logic signed [15:0] samp_val(int mode, int n, int j);
    case (mode)
      0: return (j < 2 * n && j % 2 == 0) ? 16'sd1000 : -16'sd1000;
      1: return 16'($rtoi(20000.0 * $sin(TWO_PI * real'(n) * real'(j) / real'(WIN))));
      2: return (j % 2 == 0) ? 16'sd200 : -16'sd200;
      default: return 16'sd0;
    endcase
  endfunction

  task automatic send_window(input int mode, input int n, input bit gaps, input int n_samp);
    for (int j = 0; j < n_samp; j++) begin
      DIN_VALID = 1'b1;
      DIN = samp_val(mode, n, j);
      @(posedge GCLK); #1;
      if (j == WIN - 1) end_cyc = cyc;
      if (gaps) begin
        DIN_VALID = 1'b0;
        DIN = 16'($urandom);
        @(posedge GCLK); #1;
      end
    end
    DIN_VALID = 1'b0;
    DIN = '0;
  endtask

  task automatic next_result(output res_t r, output bit ok);
    int t = 0;
    while (sv_cnt <= rd_ptr && t < 100) begin
      @(posedge GCLK); #1;
      t++;
    end
    ok = (sv_cnt > rd_ptr);
    r = ok ? res_q[rd_ptr] : '0;
    if (ok) rd_ptr++;
  endtask

  task automatic test_reset();
    logic [24:0] got;
    repeat (3) @(posedge GCLK);
    #1;
    got = {CROSS_CNT, STEP_IDX, STEP_VALID, NO_SIGNAL, LOCKED, STEP_CHANGE};
    n_cmp++;
    if (got !== 25'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", got);
    end else $display("reset_state: outputs all zero");
    reset = 1'b0;
    @(posedge GCLK); #1;
  endtask

  task automatic test_tone();
    res_t r, e;
    bit ok;
    e = '{16'd8, 4'd0, 1'b0, 1'b0, 1'b0, 8'd3};
    for (int w = 0; w < 2; w++) begin
      send_window(1, 8, 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e) begin
        n_err++;
        $display("FAIL tone w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e));
      end else $display("tone w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_no_signal_edge();
    res_t r;
    bit ok;
    int   n_x [2] = '{3, 4};
    res_t e   [2] = '{'{16'd3, 4'd0, 1'b1, 1'b0, 1'b0, 8'd2},
                      '{16'd4, 4'd0, 1'b0, 1'b0, 1'b0, 8'd3}};
    for (int w = 0; w < 2; w++) begin
      send_window(0, n_x[w], 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e[w]) begin
        n_err++;
        $display("FAIL ns_edge w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e[w]));
      end else $display("ns_edge w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_saturation();
    res_t r;
    bit ok;
    int   n_x [4] = '{128, 136, 200, 128};
    res_t e   [4] = '{'{16'd128, 4'd15, 1'b0, 1'b0, 1'b0, 8'd18},
                      '{16'd136, 4'd15, 1'b0, 1'b0, 1'b0, 8'd19},
                      '{16'd200, 4'd15, 1'b0, 1'b0, 1'b0, 8'd19},
                      '{16'd128, 4'd15, 1'b0, 1'b1, 1'b0, 8'd18}};
    for (int w = 0; w < 4; w++) begin
      send_window(0, n_x[w], 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e[w]) begin
        n_err++;
        $display("FAIL saturate w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e[w]));
      end else $display("saturate w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_noise();
    res_t r, e;
    bit ok;
    int modes [2] = '{3, 2};
    e = '{16'd0, 4'd15, 1'b1, 1'b0, 1'b0, 8'd2};
    for (int w = 0; w < 2; w++) begin
      send_window(modes[w], 0, 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e) begin
        n_err++;
        $display("FAIL noise w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e));
      end else $display("noise w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_lock();
    res_t r, e;
    bit ok;
    logic lk  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic chg [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int w = 0; w < 8; w++) begin
      if (w < 4) e = '{16'd32, 4'd3, 1'b0, lk[w], chg[w], 8'd6};
      else       e = '{16'd40, 4'd4, 1'b0, lk[w], chg[w], 8'd7};
      send_window(0, (w < 4) ? 32 : 40, 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e) begin
        n_err++;
        $display("FAIL lock w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e));
      end else $display("lock w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_wrap();
    res_t r, e;
    bit ok;
    logic lk  [5] = '{0, 0, 0, 1, 0};
    logic chg [5] = '{1, 0, 0, 0, 1};
    for (int w = 0; w < 5; w++) begin
      if (w < 4) e = '{16'd128, 4'd15, 1'b0, lk[w], chg[w], 8'd18};
      else       e = '{16'd8, 4'd0, 1'b0, lk[w], chg[w], 8'd3};
      send_window(0, (w < 4) ? 128 : 8, 1'b0, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e) begin
        n_err++;
        $display("FAIL wrap w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e));
      end else $display("wrap w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_valid_gaps();
    res_t r;
    bit ok;
    int   modes [2] = '{1, 0};
    int   n_x   [2] = '{8, 32};
    res_t e     [2] = '{'{16'd8, 4'd0, 1'b0, 1'b0, 1'b0, 8'd3},
                        '{16'd32, 4'd3, 1'b0, 1'b0, 1'b0, 8'd6}};
    for (int w = 0; w < 2; w++) begin
      send_window(modes[w], n_x[w], 1'b1, WIN);
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e[w]) begin
        n_err++;
        $display("FAIL gaps w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e[w]));
      end else $display("gaps w%0d: %s", w, fmt(r));
    end
  endtask

  task automatic test_reset_mid_window();
    res_t r, e;
    bit ok;
    logic [24:0] got;
    int base;
    base = sv_cnt;
    send_window(0, 32, 1'b0, 300);
    reset = 1'b1;
    @(posedge GCLK); #1;
    got = {CROSS_CNT, STEP_IDX, STEP_VALID, NO_SIGNAL, LOCKED, STEP_CHANGE};
    reset = 1'b0;
    n_cmp++;
    if (got !== 25'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h want 0", got);
    end else $display("rst_mid: outputs cleared");
    repeat (40) @(posedge GCLK);
    #1;
    n_cmp++;
    if (sv_cnt !== base) begin
      n_err++;
      $display("FAIL rst_mid_no_valid: got %0d results want %0d", sv_cnt, base);
    end
    e = '{16'd40, 4'd4, 1'b0, 1'b0, 1'b0, 8'd7};
    send_window(0, 40, 1'b0, WIN);
    next_result(r, ok);
    n_cmp++;
    if (!ok || r !== e) begin
      n_err++;
      $display("FAIL rst_mid_after: got %s (seen=%0b) want %s", fmt(r), ok, fmt(e));
    end else $display("rst_mid after: %s", fmt(r));
  endtask

  task automatic test_ena_mid_divide();
    res_t r, e;
    bit ok;
    logic [24:0] got;
    int base;
    base = sv_cnt;
    send_window(0, 128, 1'b0, WIN);
    repeat (5) @(posedge GCLK);
    #1;
    MODULE_ENA = 1'b0;
    @(posedge GCLK); #1;
    got = {CROSS_CNT, STEP_IDX, STEP_VALID, NO_SIGNAL, LOCKED, STEP_CHANGE};
    MODULE_ENA = 1'b1;
    n_cmp++;
    if (got !== 25'd0) begin
      n_err++;
      $display("FAIL ena_outputs: got %h want 0", got);
    end else $display("ena_low: outputs cleared mid-divide");
    repeat (40) @(posedge GCLK);
    #1;
    n_cmp++;
    if (sv_cnt !== base) begin
      n_err++;
      $display("FAIL ena_no_valid: got %0d results want %0d", sv_cnt, base);
    end
    e = '{16'd16, 4'd1, 1'b0, 1'b0, 1'b0, 8'd4};
    send_window(0, 16, 1'b0, WIN);
    next_result(r, ok);
    n_cmp++;
    if (!ok || r !== e) begin
      n_err++;
      $display("FAIL ena_after: got %s (seen=%0b) want %s", fmt(r), ok, fmt(e));
    end else $display("ena after: %s", fmt(r));
  endtask

  task automatic test_back_to_back();
    res_t r;
    bit ok;
    res_t e [2] = '{'{16'd24, 4'd2, 1'b0, 1'b0, 1'b0, 8'd5},
                    '{16'd48, 4'd5, 1'b0, 1'b0, 1'b0, 8'd8}};
    send_window(0, 24, 1'b0, WIN);
    send_window(0, 48, 1'b0, WIN);
    for (int w = 0; w < 2; w++) begin
      next_result(r, ok);
      n_cmp++;
      if (!ok || r !== e[w]) begin
        n_err++;
        $display("FAIL b2b w%0d: got %s (seen=%0b) want %s", w, fmt(r), ok, fmt(e[w]));
      end else $display("b2b w%0d: %s", w, fmt(r));
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_no_signal_edge();
    test_saturation();
    test_noise();
    test_lock();
    test_wrap();
    test_valid_gaps();
    test_reset_mid_window();
    test_ena_mid_divide();
    test_back_to_back();
    n_cmp++;
    if (orphan !== 0) begin
      n_err++;
      $display("FAIL change_coincident: got %0d stray STEP_CHANGE cycles want 0", orphan);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sweep_freq_detector.md
Name: sweep_freq_detector

Overview:
- Receive-side counterpart of the TX frequency-sweep DDS chain.
- Takes the demodulated I sample stream (16-bit signed), counts hysteresis-qualified rising zero-crossings over fixed sample windows, and converts each count into the 4-bit sweep step index (0..15) the transmitter is currently on.
- Reports lock once the estimate is stable and flags step advances, so downstream RX logic can follow the 16-step sweep.

Parameters:
- WIN_LEN, 65536: valid samples per measurement window; must be >= 64.
- STEP_CROSS, 8: expected rising crossings per window per sweep step. Phase increment 0x0800 on the 24-bit DDS phase gives f = fclk/8192, which is 8 crossings per 65536 samples.
- HYST, 16'd256: hysteresis threshold magnitude, in LSBs.
- LOCK_WINS, 4: consecutive identical estimates required to assert LOCKED.

Ports:
- GCLK  in  1  clock
- reset  in  1  synchronous, active-high
- MODULE_ENA  in  1  block enable; low behaves exactly as reset
- DIN_VALID  in  1  qualifies DIN
- DIN  in  16  signed two's-complement I sample
- CROSS_CNT  out  16  rising-crossing count of last completed window
- STEP_IDX  out  4  estimated sweep step, 0..15
- STEP_VALID  out  1  one-cycle pulse when STEP_IDX/NO_SIGNAL update
- NO_SIGNAL  out  1  last window held fewer than STEP_CROSS/2 crossings
- LOCKED  out  1  LOCK_WINS consecutive equal estimates
- STEP_CHANGE  out  1  one-cycle pulse, coincident with STEP_VALID, when the index changes while locked

Behaviour:
- Reset value 0 for: all outputs, sign state, counters and FSM (state D_IDLE).

Sign tracker
- Runs on DIN_VALID samples only.
- Sets pos when DIN > HYST; clears pos when DIN < -HYST; otherwise holds.
- Rising crossing = pos goes 0 -> 1.

Window
- samp_cnt counts DIN_VALID samples; x_cnt counts rising crossings, saturating at 16'hFFFF.
- On the valid sample where samp_cnt == WIN_LEN-1:
  - latch x_cnt (including a crossing on that same sample) into CROSS_CNT;
  - restart both counters at 0 the next cycle;
  - pulse win_done.
- Windows are back-to-back; no samples are dropped.

Divider FSM (D_IDLE -> D_SUB -> D_DONE -> D_IDLE)
- D_IDLE: on win_done, load rem = CROSS_CNT + STEP_CROSS/2 (17-bit, no overflow), q = 0, go to D_SUB.
- D_SUB: each cycle, if rem >= STEP_CROSS and q < 17, then rem -= STEP_CROSS, q++. Otherwise go to D_DONE.
- D_DONE: update outputs and pulse STEP_VALID, then return to D_IDLE.
  - q == 0: NO_SIGNAL = 1, STEP_IDX holds its previous value.
  - q >= 1: NO_SIGNAL = 0, STEP_IDX = min(q,16) - 1. Above 16, the index saturates at 15.
- Latency from win_done to STEP_VALID is q+2 cycles, 19 maximum. This always completes before the next win_done because WIN_LEN >= 64.

Lock tracking (evaluated at D_DONE)
- NO_SIGNAL: match counter = 0, LOCKED = 0.
- New index == previous index and previous result was valid: match counter++, saturating at LOCK_WINS.
- Otherwise: match counter = 1.
- LOCKED = (match counter >= LOCK_WINS), registered with STEP_VALID.
- STEP_CHANGE = 1 when LOCKED was 1 and the new index differs; LOCKED then drops to 0 in the same update.
- Step wrap 15 -> 0 is treated as an ordinary change.

Reset / enable
- reset or MODULE_ENA = 0 in any state, including mid-window or mid-divide:
  - all state returns to reset values on the next edge;
  - no STEP_VALID is emitted for the aborted window.
- The first window after release starts at sample 0.

Test Plan:
- Tone: DDS sine with phase increment 0x0800 (24-bit), continuous valid, defaults -> CROSS_CNT = 8, STEP_IDX = 0, NO_SIGNAL = 0, STEP_VALID within 19 cycles of window end.
- Increment 0x8000 (step 16) -> CROSS_CNT = 128, STEP_IDX = 15. Force 136 crossings -> STEP_IDX saturates at 15.
- DIN = 0, or ±200 noise (inside HYST) -> CROSS_CNT = 0, NO_SIGNAL = 1, LOCKED = 0, STEP_IDX unchanged.
- Four windows at step 3 -> LOCKED rises on the 4th STEP_VALID. Switch to step 4 -> STEP_CHANGE pulse, LOCKED = 0, relock after 4 more windows.
- DIN_VALID toggling 50%, same tone per valid sample -> identical CROSS_CNT/STEP_IDX; window length counted in valid samples only.
- reset pulse at sample 30000, and separately MODULE_ENA low during D_SUB -> all outputs 0 next cycle, no STEP_VALID for the aborted window, normal result after a full new window.
